// File: rtl/alu_pkg.sv
// Shared opcode encodings and response flag layout for the ALU request/response slice.
package alu_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_NOTA = 3'b101;

   typedef struct packed {
      logic carry;
      logic zero;
      logic err;
   } rsp_flags_t;

endpackage

// File: rtl/alu_req_core.sv
// Combinational ALU datapath: (a, b, op) -> (result, carry, zero, err).
module alu_req_core
   import alu_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [OP_W-1:0] op,
   output logic [W-1:0]    result,
   output logic            carry,
   output logic            zero,
   output logic            err
);

   logic [W:0] sum;
   logic [W:0] diff;

   // The (W+1)-bit difference's top bit is the unsigned borrow (a < b).
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      err    = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = sum;
         OP_SUB:  {carry, result} = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOTA: result = ~a;
         default: err = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_req_responder.sv
// ALU responder: valid/ready request in, 2-entry in-order response FIFO out.
// Optional ALU_REQ_STATS_EN adds saturating stat_ops/stat_errs counters.
module alu_req_responder
   import alu_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [W-1:0]    req_a,
   input  logic [W-1:0]    req_b,
   input  logic [OP_W-1:0] req_op,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [W-1:0]    rsp_result,
   output logic            rsp_carry,
   output logic            rsp_zero,
`ifdef ALU_REQ_STATS_EN
   output logic            rsp_err,
   output logic [15:0]     stat_ops,
   output logic [15:0]     stat_errs
`else
   output logic            rsp_err
`endif
);

   typedef struct packed {
      logic [W-1:0] result;
      rsp_flags_t   flags;
   } entry_t;

   entry_t      mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;
   entry_t      new_entry;

   alu_req_core #(.W(W)) u_core (
      .a      (req_a),
      .b      (req_b),
      .op     (req_op),
      .result (new_entry.result),
      .carry  (new_entry.flags.carry),
      .zero   (new_entry.flags.zero),
      .err    (new_entry.flags.err)
   );

   // req_ready depends only on the registered count, never on rsp_ready.
   assign req_ready = (count != 2'(DEPTH));
   assign rsp_valid = (count != 2'd0);
   assign push      = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   assign rsp_result = mem[rd_ptr].result;
   assign rsp_carry  = mem[rd_ptr].flags.carry;
   assign rsp_zero   = mem[rd_ptr].flags.zero;
   assign rsp_err    = mem[rd_ptr].flags.err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef ALU_REQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops  <= '0;
         stat_errs <= '0;
      end else if (push) begin
         if (stat_ops != '1) begin
            stat_ops <= stat_ops + 16'd1;
         end
         if (new_entry.flags.err && (stat_errs != '1)) begin
            stat_errs <= stat_errs + 16'd1;
         end
      end
   end
`endif

endmodule
